// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-record capture: latches the first qualified error, counts errors dropped
// while a record is held, and drives the level interrupt.
//
// state | meaning
// EMPTY | no record held; the next qualified error is captured
// HELD  | record frozen until software clears it; further errors are counted
module rv_iopmp_err_capture #(
   parameter int SID_WIDTH  = 8,
   parameter int ADDR_WIDTH = 64,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  err_transaction_i,
   input  logic [2:0]            err_type_i,
   input  logic [15:0]           err_entry_index_i,
   input  logic [SID_WIDTH-1:0]  err_sid_i,
   input  logic [ADDR_WIDTH-1:0] err_addr_i,
   input  logic [1:0]            err_ttype_i,
   input  logic                  ie_i,
   input  logic                  clr_i,
   output logic                  err_valid_o,
   output logic [2:0]            err_type_o,
   output logic [1:0]            err_ttype_o,
   output logic [15:0]           err_entry_index_o,
   output logic [SID_WIDTH-1:0]  err_sid_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic                  err_mv_o,
   output logic [CNT_WIDTH-1:0]  err_drop_cnt_o,
   output logic                  irq_o
);

   typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

   state_t state;
   logic   qerr;

   assign qerr        = err_transaction_i & enable_i & (err_type_i != 3'd0);
   assign err_valid_o = (state == HELD);
   assign irq_o       = err_valid_o & ie_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state             <= EMPTY;
         err_type_o        <= '0;
         err_ttype_o       <= '0;
         err_entry_index_o <= '0;
         err_sid_o         <= '0;
         err_addr_o        <= '0;
         err_mv_o          <= 1'b0;
         err_drop_cnt_o    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (qerr) begin
                  state             <= HELD;
                  err_type_o        <= err_type_i;
                  err_ttype_o       <= err_ttype_i;
                  err_entry_index_o <= err_entry_index_i;
                  err_sid_o         <= err_sid_i;
                  err_addr_o        <= err_addr_i;
               end
            end
            HELD: begin
               if (clr_i) begin
                  // Clear wins first; a same-cycle error becomes the new record.
                  err_mv_o       <= 1'b0;
                  err_drop_cnt_o <= '0;
                  if (qerr) begin
                     err_type_o        <= err_type_i;
                     err_ttype_o       <= err_ttype_i;
                     err_entry_index_o <= err_entry_index_i;
                     err_sid_o         <= err_sid_i;
                     err_addr_o        <= err_addr_i;
                  end else begin
                     state <= EMPTY;
                  end
               end else if (qerr) begin
                  err_mv_o <= 1'b1;
                  if (err_drop_cnt_o != {CNT_WIDTH{1'b1}})
                     err_drop_cnt_o <= err_drop_cnt_o + CNT_WIDTH'(1);
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: doc/rv_iopmp_err_capture.md
# rv_iopmp_err_capture

Error-record and interrupt block for the IOPMP: the receiving end of the decision logic's error interface (`err_transaction`, `err_type`, `err_entry_index`). It latches the first faulting transaction into the error-record registers and holds it until software clears it. It counts violations that arrive while a record is held, and drives the IOPMP interrupt line. It sits between the decision-logic wrapper and the IOPMP register file.

## Interface
- `SID_WIDTH`, 8, source-ID width
- `ADDR_WIDTH`, 64, transaction address width
- `CNT_WIDTH`, 8, width of the saturating dropped-error counter

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `enable_i`  in  1  IOPMP global enable; when low, incoming errors are ignored
- `err_transaction_i`  in  1  error strobe from decision logic, one cycle per faulting transaction
- `err_type_i`  in  3  error type; 0 = no error
- `err_entry_index_i`  in  16  index of the violated entry
- `err_sid_i`  in  SID_WIDTH  source ID of the faulting transaction
- `err_addr_i`  in  ADDR_WIDTH  address of the faulting transaction
- `err_ttype_i`  in  2  access type: 1 = read, 2 = write, 3 = fetch
- `ie_i`  in  1  interrupt enable (register field)
- `clr_i`  in  1  write-1-to-clear pulse for the valid bit (register write)
- `err_valid_o`  out  1  record held
- `err_type_o`  out  3  captured type
- `err_ttype_o`  out  2  captured access type
- `err_entry_index_o`  out  16  captured entry index
- `err_sid_o`  out  SID_WIDTH  captured source ID
- `err_addr_o`  out  ADDR_WIDTH  captured address
- `err_mv_o`  out  1  multiple-violation flag; at least one error was dropped while the record was held
- `err_drop_cnt_o`  out  CNT_WIDTH  number of dropped errors, saturating
- `irq_o`  out  1  interrupt, level

## Operation
- Qualified error: `qerr = err_transaction_i & enable_i & (err_type_i != 0)`. Unqualified strobes have no effect.
- FSM with two states.
  - EMPTY (reset state): on `qerr`, latch type, ttype, entry index, SID and address, then go to HELD.
  - HELD: the record is frozen.
    - On `qerr` without `clr_i`: set `err_mv_o` and increment `err_drop_cnt_o`. The counter saturates at 2^CNT_WIDTH−1 and never wraps.
    - On `clr_i` without `qerr`: go to EMPTY. Record fields keep their stale values. `err_mv_o` and `err_drop_cnt_o` clear to 0.
    - On `clr_i` and `qerr` in the same cycle: the clear applies first, then the new error is latched. The state stays HELD with the new record, `err_mv_o` = 0 and `err_drop_cnt_o` = 0.
- In EMPTY, `clr_i` has no effect.
- `err_valid_o` is 1 exactly when the state is HELD.
- `irq_o = err_valid_o & ie_i`. It is combinational from `ie_i`, so toggling `ie_i` masks or unmasks the interrupt without altering the record.
- `enable_i` low does not clear a held record, and `clr_i` still works.

## Timing
- All record outputs, `err_valid_o`, `err_mv_o` and `err_drop_cnt_o` are registered.
- A `qerr` in cycle N is visible on the outputs in cycle N+1. `irq_o` rises in N+1 if `ie_i` = 1.
- A `clr_i` in cycle N drops `err_valid_o` and `irq_o` in N+1.
- Back-to-back strobes:
  - In EMPTY, the first strobe is captured.
  - Each subsequent cycle with `qerr` counts once, including the cycle right after capture.
- Reset:
  - All outputs are 0 one cycle after `rst_i` is sampled high. This covers every record field, `err_valid_o`, `err_mv_o`, `err_drop_cnt_o` and `irq_o`.
  - `rst_i` has priority over `qerr` and `clr_i`.
  - Reset while HELD discards the record.
- Throughput: one error per cycle accepted (captured or counted); no backpressure exists.

## Test plan
- **Single capture.** Reset, `ie_i` = 1, one strobe with type 3, entry 5, SID 0x2A, address 0x8000_1000, ttype 2 → next cycle `err_valid_o` = 1 and `irq_o` = 1, fields match, `err_mv_o` = 0, count = 0.
- **Drops while held.** Capture as above, then 3 further strobes with different fields → record unchanged, `err_mv_o` = 1, count = 3. Then `clr_i` → `err_valid_o` = 0, `err_mv_o` = 0, count = 0, `irq_o` = 0.
- **Saturation.** `CNT_WIDTH` = 8, capture one error, then 300 consecutive strobes → count stops at 255, `err_mv_o` = 1.
- **Simultaneous clear and error.** While HELD with count 2, assert `clr_i` together with a strobe carrying entry 9 → next cycle `err_valid_o` = 1, entry = 9, count = 0, `err_mv_o` = 0.
- **Filtering.**
  - Strobe with `err_type_i` = 0 → no capture.
  - Strobe with `enable_i` = 0 → no capture, and no count when HELD.
  - `ie_i` = 0 with a held record → `irq_o` = 0; set `ie_i` = 1 → `irq_o` = 1 in the same cycle.
- **Reset mid-operation.** HELD with count 4, assert `rst_i` together with a strobe → next cycle all outputs 0 and state EMPTY. A following strobe is captured normally.
